// File: rtl/game_step_ctrl_if.sv
// Tile-map RAM bus between the game sequencer and the map RAM.
//   map_addr  : tile address, y*MAP_W + x
//   map_we    : write strobe
//   map_wdata : tile code written (0 EMPTY, 1 PLAYER1, 2 PLAYER2, 3 FRAME)
//   map_rdata : tile at map_addr, valid one cycle after the address
// master = sequencer side, slave = RAM side.
interface game_step_ctrl_if;
  logic [11:0] map_addr;
  logic        map_we;
  logic [1:0]  map_wdata;
  logic [1:0]  map_rdata;

  modport master (output map_addr, output map_we, output map_wdata, input map_rdata);
  modport slave  (input map_addr, input map_we, input map_wdata, output map_rdata);
endinterface

// File: rtl/game_step_ctrl.sv
// Sequencer for the two-player light-trail game. Clears and frames the tile map, places both
// players, then once per game tick advances both heads, checks collisions through map reads,
// commits the new trail tiles or declares the winner.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : 1-cycle pulse, begin/restart a game (honoured in IDLE/END only)
//   p1_dir, p2_dir  : direction requests (0 WAIT, 1 RIGHT, 2 LEFT, 3 UP, 4 DOWN)
//   pause           : only with GAME_PAUSE_EN defined; stalls the tick counter in RUN
//   map             : tile-map RAM bus (master modport)
//   mode            : 0 START, 1 GAME, 2 PLAYER1_WIN, 3 PLAYER2_WIN, 4 GAME_OVER
//   p1_x/p1_y/p2_x/p2_y : head tiles
//   busy            : high while clearing, placing or stepping
// Build option: define GAME_PAUSE_EN to add the pause input.
module game_step_ctrl #(
  parameter int unsigned MAP_W    = 64,
  parameter int unsigned MAP_H    = 48,
  parameter int unsigned TICK_DIV = 2_000_000,
  parameter int unsigned P1_X0    = 10,
  parameter int unsigned P1_Y0    = 18,
  parameter int unsigned P2_X0    = 53,
  parameter int unsigned P2_Y0    = 29
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              p1_dir,
  input  logic [2:0]              p2_dir,
`ifdef GAME_PAUSE_EN
  input  logic                    pause,
`endif
  game_step_ctrl_if.master        map,
  output logic [2:0]              mode,
  output logic [7:0]              p1_x,
  output logic [7:0]              p1_y,
  output logic [7:0]              p2_x,
  output logic [7:0]              p2_y,
  output logic                    busy
);

  localparam logic [2:0] DirRight = 3'd1, DirLeft = 3'd2, DirUp = 3'd3, DirDown = 3'd4;
  localparam logic [1:0] TileEmpty = 2'd0, TileP1 = 2'd1, TileP2 = 2'd2, TileFrame = 2'd3;
  localparam logic [2:0] ModeStart = 3'd0, ModeGame = 3'd1, ModeP1Win = 3'd2;
  localparam logic [2:0] ModeP2Win = 3'd3, ModeOver = 3'd4;
  localparam logic [7:0] XLast = 8'(MAP_W - 1);
  localparam logic [7:0] YLast = 8'(MAP_H - 1);
  localparam logic [7:0] P1X = 8'(P1_X0), P1Y = 8'(P1_Y0), P2X = 8'(P2_X0), P2Y = 8'(P2_Y0);
  localparam logic [31:0] TickLast = 32'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle, StClear, StPlace, StRun, StCalc, StRd1, StRd2, StChk, StWr1, StWr2, StEnd
  } state_e;

  function automatic logic [11:0] tile_addr(input logic [7:0] tx, input logic [7:0] ty);
    return 12'((32'(ty) * MAP_W) + 32'(tx));
  endfunction

  function automatic logic is_frame(input logic [7:0] fx, input logic [7:0] fy);
    return (fx == 8'd0) || (fx == XLast) || (fy == 8'd0) || (fy == YLast);
  endfunction

  function automatic logic is_dir(input logic [2:0] dc);
    return (dc >= DirRight) && (dc <= DirDown);
  endfunction

  function automatic logic is_opp(input logic [2:0] da, input logic [2:0] db);
    return ((da == DirRight) && (db == DirLeft)) || ((da == DirLeft) && (db == DirRight)) ||
           ((da == DirUp) && (db == DirDown)) || ((da == DirDown) && (db == DirUp));
  endfunction

  function automatic logic [7:0] move_x(input logic [7:0] cx, input logic [2:0] dc);
    case (dc)
      DirRight: return cx + 8'd1;
      DirLeft:  return cx - 8'd1;
      default:  return cx;
    endcase
  endfunction

  function automatic logic [7:0] move_y(input logic [7:0] cy, input logic [2:0] dc);
    case (dc)
      DirDown: return cy + 8'd1;
      DirUp:   return cy - 8'd1;
      default: return cy;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [11:0] addr_q, addr_d;
  logic        we_q, we_d, busy_q, busy_d, place_q, place_d;
  logic [1:0]  wdata_q, wdata_d, tile1_q, tile1_d;
  logic [7:0]  h1x_q, h1x_d, h1y_q, h1y_d, h2x_q, h2x_d, h2y_q, h2y_d;
  logic [7:0]  n1x_q, n1x_d, n1y_q, n1y_d, n2x_q, n2x_d, n2y_q, n2y_d;
  logic [2:0]  dir1_q, dir1_d, dir2_q, dir2_d, pend1_q, pend1_d, pend2_q, pend2_d;
  logic [31:0] tick_q, tick_d, tick_nxt;
  logic [7:0]  clr_x_q, clr_x_d, clr_y_q, clr_y_d, clr_nx, clr_ny;
  logic [2:0]  nd1, nd2;
  logic [7:0]  c1x, c1y, c2x, c2y;
  logic        clr_last, same_tile, crash1, crash2, run_hold;

`ifdef GAME_PAUSE_EN
  assign run_hold = pause;
`else
  assign run_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;  mode_d  = mode_q;   addr_d  = addr_q;
    we_d    = 1'b0;     wdata_d = TileEmpty;
    h1x_d = h1x_q;  h1y_d = h1y_q;  h2x_d = h2x_q;  h2y_d = h2y_q;
    n1x_d = n1x_q;  n1y_d = n1y_q;  n2x_d = n2x_q;  n2y_d = n2y_q;
    dir1_d = dir1_q;  dir2_d = dir2_q;  pend1_d = pend1_q;  pend2_d = pend2_q;
    tile1_d = tile1_q;  tick_d = tick_q;  place_d = place_q;
    clr_x_d = clr_x_q;  clr_y_d = clr_y_q;

    clr_last = (clr_x_q == XLast) && (clr_y_q == YLast);
    clr_nx   = (clr_x_q == XLast) ? 8'd0 : clr_x_q + 8'd1;
    clr_ny   = (clr_x_q == XLast) ? clr_y_q + 8'd1 : clr_y_q;
    nd1      = (is_dir(pend1_q) && !is_opp(pend1_q, dir1_q)) ? pend1_q : dir1_q;
    nd2      = (is_dir(pend2_q) && !is_opp(pend2_q, dir2_q)) ? pend2_q : dir2_q;
    c1x = move_x(h1x_q, nd1);  c1y = move_y(h1y_q, nd1);
    c2x = move_x(h2x_q, nd2);  c2y = move_y(h2y_q, nd2);
    same_tile = (n1x_q == n2x_q) && (n1y_q == n2y_q);
    crash1    = (tile1_q != TileEmpty) || same_tile;
    // In CHK the RAM is returning the P2 target tile read issued in RD2.
    crash2    = (map.map_rdata != TileEmpty) || same_tile;
    tick_nxt  = (tick_q == TickLast) ? '0 : tick_q + 32'd1;

    if ((state_q != StIdle) && (state_q != StEnd)) begin
      if (is_dir(p1_dir)) pend1_d = p1_dir;
      if (is_dir(p2_dir)) pend2_d = p2_dir;
    end

    case (state_q)
      StIdle, StEnd: begin
        if (start) begin
          state_d = StClear;
          clr_x_d = 8'd0;  clr_y_d = 8'd0;
          addr_d  = '0;    we_d    = 1'b1;  wdata_d = TileFrame;
          tick_d  = '0;
        end
      end
      StClear: begin
        we_d = 1'b1;
        if (clr_last) begin
          state_d = StPlace;  place_d = 1'b0;
          addr_d  = tile_addr(P1X, P1Y);  wdata_d = TileP1;
        end else begin
          clr_x_d = clr_nx;  clr_y_d = clr_ny;
          addr_d  = tile_addr(clr_nx, clr_ny);
          wdata_d = is_frame(clr_nx, clr_ny) ? TileFrame : TileEmpty;
        end
      end
      StPlace: begin
        if (!place_q) begin
          place_d = 1'b1;  addr_d = tile_addr(P2X, P2Y);  we_d = 1'b1;  wdata_d = TileP2;
        end else begin
          state_d = StRun;  mode_d = ModeGame;  tick_d = '0;
          h1x_d = P1X;  h1y_d = P1Y;  h2x_d = P2X;  h2y_d = P2Y;
          dir1_d = DirRight;  dir2_d = DirLeft;  pend1_d = '0;  pend2_d = '0;
        end
      end
      StRun: begin
        if (!run_hold) begin
          tick_d = tick_nxt;
          if (tick_q == TickLast) state_d = StCalc;
        end
      end
      StCalc: begin
        tick_d = tick_nxt;
        dir1_d = nd1;  dir2_d = nd2;
        // A request arriving in this very cycle survives for the next tick.
        if (!is_dir(p1_dir)) pend1_d = '0;
        if (!is_dir(p2_dir)) pend2_d = '0;
        n1x_d = c1x;  n1y_d = c1y;  n2x_d = c2x;  n2y_d = c2y;
        addr_d  = tile_addr(c1x, c1y);
        state_d = StRd1;
      end
      StRd1: begin
        tick_d  = tick_nxt;
        addr_d  = tile_addr(n2x_q, n2y_q);
        state_d = StRd2;
      end
      StRd2: begin
        tick_d  = tick_nxt;
        tile1_d = map.map_rdata;
        state_d = StChk;
      end
      StChk: begin
        tick_d = tick_nxt;
        if (crash1 || crash2) begin
          state_d = StEnd;
          mode_d  = (crash1 && crash2) ? ModeOver : (crash1 ? ModeP2Win : ModeP1Win);
        end else begin
          state_d = StWr1;  addr_d = tile_addr(n1x_q, n1y_q);  we_d = 1'b1;  wdata_d = TileP1;
        end
      end
      StWr1: begin
        tick_d  = tick_nxt;
        state_d = StWr2;  addr_d = tile_addr(n2x_q, n2y_q);  we_d = 1'b1;  wdata_d = TileP2;
      end
      StWr2: begin
        tick_d  = tick_nxt;
        h1x_d = n1x_q;  h1y_d = n1y_q;  h2x_d = n2x_q;  h2y_d = n2y_q;
        state_d = StRun;
      end
      default: state_d = StIdle;
    endcase

    case (state_d)
      StClear, StPlace, StCalc, StRd1, StRd2, StChk, StWr1, StWr2: busy_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;   mode_q  <= ModeStart;  addr_q  <= '0;
      we_q    <= 1'b0;     wdata_q <= TileEmpty;  busy_q  <= 1'b0;
      h1x_q <= P1X;  h1y_q <= P1Y;  h2x_q <= P2X;  h2y_q <= P2Y;
      n1x_q <= '0;   n1y_q <= '0;   n2x_q <= '0;   n2y_q <= '0;
      dir1_q <= DirRight;  dir2_q <= DirLeft;  pend1_q <= '0;  pend2_q <= '0;
      tile1_q <= TileEmpty;  tick_q <= '0;  place_q <= 1'b0;
      clr_x_q <= '0;  clr_y_q <= '0;
    end else begin
      state_q <= state_d;  mode_q  <= mode_d;   addr_q  <= addr_d;
      we_q    <= we_d;     wdata_q <= wdata_d;  busy_q  <= busy_d;
      h1x_q <= h1x_d;  h1y_q <= h1y_d;  h2x_q <= h2x_d;  h2y_q <= h2y_d;
      n1x_q <= n1x_d;  n1y_q <= n1y_d;  n2x_q <= n2x_d;  n2y_q <= n2y_d;
      dir1_q <= dir1_d;  dir2_q <= dir2_d;  pend1_q <= pend1_d;  pend2_q <= pend2_d;
      tile1_q <= tile1_d;  tick_q <= tick_d;  place_q <= place_d;
      clr_x_q <= clr_x_d;  clr_y_q <= clr_y_d;
    end
  end

  assign map.map_addr  = addr_q;
  assign map.map_we    = we_q;
  assign map.map_wdata = wdata_q;
  assign mode = mode_q;
  assign busy = busy_q;
  assign p1_x = h1x_q;
  assign p1_y = h1y_q;
  assign p2_x = h2x_q;
  assign p2_y = h2y_q;

endmodule

// File: tb/tb_game_step_ctrl.sv
module tb_game_step_ctrl;
  localparam int W  = 64;
  localparam int H  = 48;
  localparam int TD = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] p1_dir = 3'd0;
  logic [2:0] p2_dir = 3'd0;
`ifdef GAME_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [2:0] mode;
  logic [7:0] p1_x, p1_y, p2_x, p2_y;
  logic       busy;

  game_step_ctrl_if map_if ();

  game_step_ctrl #(.TICK_DIV(TD)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .p1_dir (p1_dir),
    .p2_dir (p2_dir),
`ifdef GAME_PAUSE_EN
    .pause  (pause),
`endif
    .map    (map_if),
    .mode   (mode),
    .p1_x   (p1_x),
    .p1_y   (p1_y),
    .p2_x   (p2_x),
    .p2_y   (p2_y),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Map RAM with one-cycle read latency, plus a log of every write seen on the bus.
  logic [1:0]  mem [W*H];
  logic [13:0] wq [$];
  always @(posedge clk) begin
    if (map_if.map_we === 1'b1) begin
      mem[map_if.map_addr] <= map_if.map_wdata;
      wq.push_back({map_if.map_addr, map_if.map_wdata});
    end
    map_if.map_rdata <= mem[map_if.map_addr];
  end

  int ncmp = 0;
  int nfail = 0;

  // Reference game: tile grid, heads, directions, pending requests, mode.
  logic [1:0] grid [W*H];
  int hx1, hy1, hx2, hy2, dr1, dr2, pd1, pd2, mode_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit opp(input int a, input int b);
    return (a == 1 && b == 2) || (a == 2 && b == 1) || (a == 3 && b == 4) || (a == 4 && b == 3);
  endfunction

  function automatic int dxf(input int d);
    return (d == 1) ? 1 : ((d == 2) ? -1 : 0);
  endfunction

  function automatic int dyf(input int d);
    return (d == 4) ? 1 : ((d == 3) ? -1 : 0);
  endfunction

  task automatic model_new_game();
    for (int i = 0; i < W*H; i++) begin
      grid[i] = ((i % W) == 0 || (i % W) == W-1 || (i / W) == 0 || (i / W) == H-1) ? 2'd3 : 2'd0;
    end
    grid[18*W + 10] = 2'd1;
    grid[29*W + 53] = 2'd2;
    hx1 = 10; hy1 = 18; hx2 = 53; hy2 = 29;
    dr1 = 1; dr2 = 2; pd1 = 0; pd2 = 0; mode_m = 1;
  endtask

  task automatic wait_busy(input logic v, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (busy === v) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic restart();
    bit ok;
    int bad, x, y;
    logic [13:0] e, e1, e2, e0, e65;
    wq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clear_busy", busy, 1);
    chk("clear_we", map_if.map_we, 1);
    ok = 1'b0;
    for (int i = 0; i < W*H + 20; i++) begin
      if (mode === 3'd1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("place_done", ok, 1);
    chk("n_clear_place", wq.size(), W*H + 2);
    bad = 0;
    for (int i = 0; i < W*H; i++) begin
      x = i % W;
      y = i / W;
      e = {i[11:0], (x == 0 || x == W-1 || y == 0 || y == H-1) ? 2'd3 : 2'd0};
      if (i >= wq.size()) bad++;
      else if (wq[i] !== e) bad++;
    end
    chk("clear_seq", bad, 0);
    e0  = (wq.size() > 0)      ? wq[0]      : '1;
    e65 = (wq.size() > 65)     ? wq[65]     : '1;
    e1  = (wq.size() > W*H)    ? wq[W*H]    : '1;
    e2  = (wq.size() > W*H+1)  ? wq[W*H+1]  : '1;
    chk("clear_addr0_frame", e0, {12'd0, 2'd3});
    chk("clear_addr65_empty", e65, {12'd65, 2'd0});
    chk("place_p1", e1, {12'd1162, 2'd1});
    chk("place_p2", e2, {12'd1909, 2'd2});
    chk("place_busy", busy, 0);
    model_new_game();
  endtask

  task automatic do_step(input logic [2:0] r1, input logic [2:0] r2);
    bit ok, c1, c2;
    int nx1, ny1, nx2, ny2, a1, a2;
    logic [13:0] w0, w1;
    wq.delete();
    if (r1 != 3'd0) pd1 = int'(r1);
    if (r2 != 3'd0) pd2 = int'(r2);
    p1_dir = r1;
    p2_dir = r2;
    @(negedge clk);
    p1_dir = 3'd0;
    p2_dir = 3'd0;
    wait_busy(1'b1, TD + 40, ok);
    chk("step_start", ok, 1);
    wait_busy(1'b0, 20, ok);
    chk("step_end", ok, 1);
    if (pd1 != 0 && !opp(pd1, dr1)) dr1 = pd1;
    if (pd2 != 0 && !opp(pd2, dr2)) dr2 = pd2;
    pd1 = 0;
    pd2 = 0;
    nx1 = hx1 + dxf(dr1); ny1 = hy1 + dyf(dr1);
    nx2 = hx2 + dxf(dr2); ny2 = hy2 + dyf(dr2);
    a1 = ny1*W + nx1;
    a2 = ny2*W + nx2;
    c1 = (grid[a1] != 2'd0) || (a1 == a2);
    c2 = (grid[a2] != 2'd0) || (a1 == a2);
    if (!c1 && !c2) begin
      grid[a1] = 2'd1;
      grid[a2] = 2'd2;
      hx1 = nx1; hy1 = ny1; hx2 = nx2; hy2 = ny2;
    end else begin
      mode_m = (c1 && c2) ? 4 : (c1 ? 3 : 2);
    end
    chk("step_mode", mode, mode_m);
    chk("step_p1x", p1_x, hx1);
    chk("step_p1y", p1_y, hy1);
    chk("step_p2x", p2_x, hx2);
    chk("step_p2y", p2_y, hy2);
    chk("step_busy", busy, 0);
    if (!c1 && !c2) begin
      chk("step_nwr", wq.size(), 2);
      w0 = (wq.size() > 0) ? wq[0] : '1;
      w1 = (wq.size() > 1) ? wq[1] : '1;
      chk("step_wr1", w0, {a1[11:0], 2'd1});
      chk("step_wr2", w1, {a2[11:0], 2'd2});
    end else begin
      chk("crash_nwr", wq.size(), 0);
    end
  endtask

  initial begin
    bit ok;
    logic [2:0] r1, r2;
    logic [13:0] w;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mode", mode, 0);
    chk("rst_we", map_if.map_we, 0);
    chk("rst_addr", map_if.map_addr, 0);
    chk("rst_wdata", map_if.map_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p1x", p1_x, 10);
    chk("rst_p1y", p1_y, 18);
    chk("rst_p2x", p2_x, 53);
    chk("rst_p2y", p2_y, 29);

    restart();
    chk("game_mode", mode, 1);

    // First tick with no input.
    do_step(3'd0, 3'd0);
    chk("t1_p1x", p1_x, 11);
    chk("t1_p2x", p2_x, 52);
    w = (wq.size() > 0) ? wq[0] : '1;
    chk("t1_wr1", w, {12'd1163, 2'd1});
    w = (wq.size() > 1) ? wq[1] : '1;
    chk("t1_wr2", w, {12'd1908, 2'd2});

    // Reverse request is discarded.
    do_step(3'd2, 3'd0);
    chk("rev_p1x", p1_x, 12);
    chk("rev_p1y", p1_y, 18);

    // UP then WAIT.
    do_step(3'd3, 3'd0);
    chk("up_p1y", p1_y, 17);

    // Steer P1 left into the frame.
    do_step(3'd2, 3'd0);
    for (int i = 0; i < 20 && mode_m == 1; i++) do_step(3'd0, 3'd0);
    chk("frame_mode", mode, 3);
    chk("frame_p1x", p1_x, 1);
    chk("frame_busy", busy, 0);

    // Both heads aim at (35,20) on the same tick.
    restart();
    do_step(3'd4, 3'd3);
    do_step(3'd0, 3'd0);
    do_step(3'd1, 3'd0);
    for (int i = 4; i <= 9; i++) do_step(3'd0, 3'd0);
    do_step(3'd0, 3'd2);
    for (int i = 0; i < 25 && mode_m == 1; i++) do_step(3'd0, 3'd0);
    chk("same_mode", mode, 4);
    chk("same_p1x", p1_x, 34);
    chk("same_p2x", p2_x, 36);

    restart();
    chk("restart_mode", mode, 1);

    // Random play against the model.
    for (int g = 0; g < 4; g++) begin
      if (mode_m != 1) restart();
      for (int s = 0; s < 40 && mode_m == 1; s++) begin
        r1 = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
        r2 = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
        do_step(r1, r2);
      end
    end

`ifdef GAME_PAUSE_EN
    if (mode_m != 1) restart();
    pause = 1'b1;
    repeat (5*TD) @(negedge clk);
    chk("pause_p1x", p1_x, hx1);
    chk("pause_p2x", p2_x, hx2);
    chk("pause_busy", busy, 0);
    pause = 1'b0;
    do_step(3'd0, 3'd0);
`endif

    // Reset in the middle of CLEAR.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (map_if.map_addr === 12'd1000) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("addr1000_seen", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_mode", mode, 0);
    chk("midrst_we", map_if.map_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", map_if.map_addr, 0);
    chk("midrst_wdata", map_if.map_wdata, 0);
    chk("midrst_p1x", p1_x, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
